// File: rtl/adc_tx_pkg.sv
// rtl/adc_tx_pkg.sv - shared types and constants for the ADC acquisition/UART sequencer
package adc_tx_pkg;

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_NEXT, S_LOAD, S_WAIT, S_DONE} state_t;
  typedef enum logic [2:0] {G_HDR, G_MSK, G_HI, G_LO, G_CSM, G_END} seg_t;

  localparam logic [7:0] HDR_BYTE    = 8'hA5;
  localparam int         SPI_PERIODS = 24;
  localparam int         RES_W       = 12;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/adc_spi_xfer.sv
// rtl/adc_spi_xfer.sv - one 24-period ADC SPI transaction: 8-bit command out, 12-bit result in
module adc_spi_xfer import adc_tx_pkg::*; #(
  parameter int KMAX = 39
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       cmd_i,
  input  logic             miso_i,
  output logic             cs_o,
  output logic             dclk_o,
  output logic             mosi_o,
  output logic             done_o,
  output logic [RES_W-1:0] result_o
);

  localparam int CW = $clog2(KMAX + 2);

  logic             act_q, lead_q, half_q;
  logic [4:0]       per_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       cmd_q;
  logic [RES_W-1:0] sh_q;
  logic             cs_q, dclk_q, mosi_q, done_q;
  logic             tick;

  assign tick = (cnt_q == CW'(KMAX));

  // A lead-in half period with cs high guarantees the inter-transaction gap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q <= 1'b0; lead_q <= 1'b0; half_q <= 1'b0; per_q <= '0; cnt_q <= '0;
      cmd_q <= '0; sh_q <= '0; cs_q <= 1'b1; dclk_q <= 1'b0; mosi_q <= 1'b0; done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!act_q) begin
        if (start_i) begin
          act_q <= 1'b1; lead_q <= 1'b1; cnt_q <= '0; cmd_q <= cmd_i;
        end
      end else begin
        cnt_q <= tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          if (lead_q) begin
            lead_q <= 1'b0; cs_q <= 1'b0; per_q <= '0; half_q <= 1'b0;
            mosi_q <= cmd_q[7]; cmd_q <= {cmd_q[6:0], 1'b0};
          end else if (!half_q) begin
            half_q <= 1'b1; dclk_q <= 1'b1;
            if (per_q >= 5'd12) sh_q <= {sh_q[RES_W-2:0], miso_i};
          end else begin
            half_q <= 1'b0; dclk_q <= 1'b0;
            if (per_q == 5'(SPI_PERIODS - 1)) begin
              cs_q <= 1'b1; mosi_q <= 1'b0; act_q <= 1'b0; done_q <= 1'b1;
            end else begin
              per_q <= per_q + 5'd1;
              mosi_q <= cmd_q[7]; cmd_q <= {cmd_q[6:0], 1'b0};
            end
          end
        end
      end
    end
  end

  assign cs_o     = cs_q;
  assign dclk_o   = dclk_q;
  assign mosi_o   = mosi_q;
  assign done_o   = done_q;
  assign result_o = sh_q;

endmodule

// File: rtl/rs232_tx.sv
// rtl/rs232_tx.sv - 8N1 UART transmitter with st_i/eot_o handshake, LSB first
module rs232_tx #(
  parameter int BAUD = 10415
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       st_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       eot_o
);

  logic        busy_q, tx_q, eot_q;
  logic [3:0]  bit_q;
  logic [31:0] cnt_q;
  logic [8:0]  sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0; tx_q <= 1'b1; eot_q <= 1'b0; bit_q <= '0; cnt_q <= '0; sh_q <= '0;
    end else begin
      eot_q <= 1'b0;
      if (!busy_q) begin
        if (st_i) begin
          busy_q <= 1'b1; sh_q <= {1'b1, data_i}; tx_q <= 1'b0; bit_q <= '0; cnt_q <= '0;
        end
      end else if (cnt_q == 32'(BAUD - 1)) begin
        cnt_q <= '0;
        if (bit_q == 4'd9) begin
          busy_q <= 1'b0; eot_q <= 1'b1; tx_q <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1; tx_q <= sh_q[0]; sh_q <= {1'b1, sh_q[8:1]};
        end
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign tx_o  = tx_q;
  assign eot_o = eot_q;

endmodule

// File: rtl/adc_tx_nch_seq.sv
// rtl/adc_tx_nch_seq.sv - multi-channel ADC acquisition sequencer sending each frame over UART
module adc_tx_nch_seq import adc_tx_pkg::*; #(
  parameter int NCH    = 2,
  parameter int KMAX   = 39,
  parameter int BAUD   = 10415,
  parameter int PERIOD = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trig_i,
  input  logic             en_i,
  input  logic [NCH-1:0]   ch_mask_i,
  input  logic             miso_i,
  output logic             mosi_o,
  output logic             dclk_o,
  output logic             cs_o,
  output logic             tx_o,
  output logic [RES_W-1:0] dout_o,
  output logic [2:0]       ch_o,
  output logic             dvalid_o,
  output logic             busy_o,
  output logic             eoa_o,
  output logic             ovr_o
);

  state_t           state_q;
  seg_t             seg_q;
  logic [7:0]       mask_q, csum_q, txd_q, mask_in, rem, byte_d;
  logic [2:0]       ch_q, cho_q, first_in, first_q, next_idx;
  logic [RES_W-1:0] res_q [8];
  logic [RES_W-1:0] dout_q, spi_res;
  logic [31:0]      tmr_q;
  logic             tick, trig, has_next, load, eot, spi_done;
  logic             st_q, spi_start_q, dvalid_q, busy_q, eoa_q, ovr_q;

  assign mask_in  = 8'(ch_mask_i);
  assign first_in = lowest_set(mask_in);
  assign first_q  = lowest_set(mask_q);
  assign rem      = mask_q & ~((8'd2 << ch_q) - 8'd1);
  assign next_idx = lowest_set(rem);
  assign has_next = |rem;
  assign tick     = (PERIOD > 0) && en_i && (tmr_q == 32'(PERIOD - 1));
  assign trig     = trig_i || tick;
  assign load     = (state_q == S_NEXT && !has_next) || (state_q == S_WAIT && eot && seg_q != G_END);

  always_comb begin
    byte_d = 8'h00;
    case (seg_q)
      G_HDR:   byte_d = HDR_BYTE;
      G_MSK:   byte_d = mask_q;
      G_HI:    byte_d = {4'h0, res_q[ch_q][11:8]};
      G_LO:    byte_d = res_q[ch_q][7:0];
      G_CSM:   byte_d = csum_q;
      default: byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE; seg_q <= G_HDR; mask_q <= '0; csum_q <= '0; txd_q <= '0;
      ch_q <= '0; cho_q <= '0; dout_q <= '0; tmr_q <= '0; st_q <= 1'b0; spi_start_q <= 1'b0;
      dvalid_q <= 1'b0; busy_q <= 1'b0; eoa_q <= 1'b0; ovr_q <= 1'b0;
      for (int i = 0; i < 8; i++) res_q[i] <= '0;
    end else begin
      dvalid_q <= 1'b0; eoa_q <= 1'b0; ovr_q <= 1'b0; spi_start_q <= 1'b0; st_q <= 1'b0;
      tmr_q <= (PERIOD > 0 && en_i && !tick) ? tmr_q + 32'd1 : '0;
      if (trig && state_q != S_IDLE) ovr_q <= 1'b1;
      case (state_q)
        S_IDLE: if (trig && mask_in != 8'h00) begin
          mask_q <= mask_in; ch_q <= first_in; busy_q <= 1'b1;
          spi_start_q <= 1'b1; seg_q <= G_HDR; state_q <= S_CONV;
        end
        S_CONV: if (spi_done) begin
          dout_q <= spi_res; cho_q <= ch_q; dvalid_q <= 1'b1;
          res_q[ch_q] <= spi_res; state_q <= S_NEXT;
        end
        S_NEXT: if (has_next) begin
          ch_q <= next_idx; spi_start_q <= 1'b1; state_q <= S_CONV;
        end else begin
          state_q <= S_LOAD;
        end
        S_LOAD: state_q <= S_WAIT;
        S_WAIT: if (eot) begin
          if (seg_q == G_END) begin
            eoa_q <= 1'b1; busy_q <= 1'b0; state_q <= S_DONE;
          end else begin
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Byte issue: the header resets the checksum, every later byte except the checksum folds in.
      if (load) begin
        st_q <= 1'b1; txd_q <= byte_d;
        case (seg_q)
          G_HDR: begin csum_q <= 8'h00; seg_q <= G_MSK; end
          G_MSK: begin csum_q <= csum_q ^ byte_d; ch_q <= first_q; seg_q <= G_HI; end
          G_HI:  begin csum_q <= csum_q ^ byte_d; seg_q <= G_LO; end
          G_LO: begin
            csum_q <= csum_q ^ byte_d;
            if (has_next) begin ch_q <= next_idx; seg_q <= G_HI; end
            else seg_q <= G_CSM;
          end
          default: seg_q <= G_END;
        endcase
      end
    end
  end

  adc_spi_xfer #(.KMAX(KMAX)) u_spi (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(spi_start_q), .cmd_i({2'b11, ch_q, 3'b000}),
    .miso_i(miso_i), .cs_o(cs_o), .dclk_o(dclk_o), .mosi_o(mosi_o),
    .done_o(spi_done), .result_o(spi_res)
  );

  rs232_tx #(.BAUD(BAUD)) u_uart (
    .clk_i(clk_i), .rst_i(rst_i), .st_i(st_q), .data_i(txd_q), .tx_o(tx_o), .eot_o(eot)
  );

  assign dout_o   = dout_q;
  assign ch_o     = cho_q;
  assign dvalid_o = dvalid_q;
  assign busy_o   = busy_q;
  assign eoa_o    = eoa_q;
  assign ovr_o    = ovr_q;

endmodule

// File: tb/tb_adc_tx_nch_seq.sv
// tb/tb_adc_tx_nch_seq.sv - randomized self-checking bench for adc_tx_nch_seq
module tb_adc_tx_nch_seq;

  localparam int NCH = 2, KMAX = 1, BAUD = 8, PERIOD = 1500;
  localparam int CS_LOW = 48 * (KMAX + 1);

  logic clk = 1'b0, rst = 1'b1, trig = 1'b0, en = 1'b0, miso = 1'b0;
  logic [NCH-1:0] mask = '0;
  logic mosi_o, dclk_o, cs_o, tx_o, dvalid_o, busy_o, eoa_o, ovr_o;
  logic [11:0] dout_o;
  logic [2:0]  ch_o;

  adc_tx_nch_seq #(.NCH(NCH), .KMAX(KMAX), .BAUD(BAUD), .PERIOD(PERIOD)) dut (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .en_i(en), .ch_mask_i(mask), .miso_i(miso),
    .mosi_o(mosi_o), .dclk_o(dclk_o), .cs_o(cs_o), .tx_o(tx_o), .dout_o(dout_o), .ch_o(ch_o),
    .dvalid_o(dvalid_o), .busy_o(busy_o), .eoa_o(eoa_o), .ovr_o(ovr_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [11:0] adc_val [8];
  logic [7:0]  rx_log[$], cmd_log[$], exp_bytes[$], exp_cmd[$];
  logic [14:0] dv_log[$], exp_dv[$];
  int          cs_len_log[$], busy_t[$];
  int          eoa_cnt = 0, ovr_cnt = 0, cyc = 0, per = 0, cs_low_len = 0, cs_hi_len = 0;
  logic        prev_cs = 1'b1, prev_dclk = 1'b0, prev_busy = 1'b0;
  logic        busy_seen = 1'b0, tx_seen_low = 1'b0, cs_seen_low = 1'b0;
  logic [7:0]  cmd_sr = '0;

  // ADC model plus bus monitors, all sampled on the falling clk edge.
  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !cs_o) begin
      chk("cs_gap", (cs_hi_len >= KMAX + 1), 1);
      per = 0; cmd_sr = '0; cs_low_len = 0;
    end
    if (!cs_o) begin
      cs_low_len++;
      if (!prev_dclk && dclk_o && per < 8) cmd_sr = {cmd_sr[6:0], mosi_o};
      if (prev_dclk && !dclk_o) begin
        per++;
        if (per == 8) cmd_log.push_back(cmd_sr);
        miso = (per >= 12 && per <= 23) ? adc_val[cmd_sr[5:3]][23 - per] : 1'b0;
      end
    end else begin
      cs_hi_len++;
      miso = 1'b0;
    end
    if (!prev_cs && cs_o) begin
      if (!rst) cs_len_log.push_back(cs_low_len);
      cs_hi_len = 1;
    end
    if (dvalid_o) dv_log.push_back({ch_o, dout_o});
    if (eoa_o) eoa_cnt++;
    if (ovr_o) ovr_cnt++;
    if (busy_o && !prev_busy) busy_t.push_back(cyc);
    if (busy_o) busy_seen = 1'b1;
    if (!tx_o) tx_seen_low = 1'b1;
    if (!cs_o) cs_seen_low = 1'b1;
    prev_cs = cs_o; prev_dclk = dclk_o; prev_busy = busy_o;
  end

  initial begin : uart_rx
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && tx_o === 1'b0) begin
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = tx_o;
        end
        repeat (BAUD) @(negedge clk);
        rx_log.push_back(b);
      end
    end
  end

  task automatic build_exp(input logic [NCH-1:0] m);
    logic [7:0] x;
    exp_bytes.delete(); exp_dv.delete(); exp_cmd.delete();
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'(m));
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        exp_bytes.push_back({4'h0, adc_val[c][11:8]});
        exp_bytes.push_back(adc_val[c][7:0]);
        exp_dv.push_back({3'(c), adc_val[c]});
        exp_cmd.push_back({2'b11, 3'(c), 3'b000});
      end
    end
    x = 8'h00;
    for (int i = 1; i < exp_bytes.size(); i++) x = x ^ exp_bytes[i];
    exp_bytes.push_back(x);
  endtask

  task automatic clear_logs();
    rx_log.delete(); cmd_log.delete(); dv_log.delete(); cs_len_log.delete(); busy_t.delete();
    eoa_cnt = 0; ovr_cnt = 0; busy_seen = 1'b0; tx_seen_low = 1'b0; cs_seen_low = 1'b0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_eoa(input string tag);
    int n = 0;
    while (eoa_o !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    chk({tag, "_eoa_seen"}, (n < 6000), 1);
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, "_eoa_cnt"}, eoa_cnt, 1);
    chk({tag, "_nbytes"}, rx_log.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < rx_log.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), rx_log[i], exp_bytes[i]);
    chk({tag, "_ndv"}, dv_log.size(), exp_dv.size());
    for (int i = 0; i < exp_dv.size() && i < dv_log.size(); i++)
      chk($sformatf("%s_dv%0d", tag, i), dv_log[i], exp_dv[i]);
    chk({tag, "_ncmd"}, cmd_log.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < cmd_log.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), cmd_log[i], exp_cmd[i]);
    for (int i = 0; i < cs_len_log.size(); i++)
      chk($sformatf("%s_cslow%0d", tag, i), cs_len_log[i], CS_LOW);
    chk({tag, "_busy_end"}, busy_o, 0);
  endtask

  task automatic run_frame(input logic [NCH-1:0] m, input string tag);
    clear_logs();
    build_exp(m);
    mask = m;
    pulse_trig();
    wait_eoa(tag);
    repeat (4) @(negedge clk);
    compare_frame(tag);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cs"}, cs_o, 1);      chk({tag, "_dclk"}, dclk_o, 0);
    chk({tag, "_mosi"}, mosi_o, 0);  chk({tag, "_tx"}, tx_o, 1);
    chk({tag, "_dout"}, dout_o, 0);  chk({tag, "_ch"}, ch_o, 0);
    chk({tag, "_dvalid"}, dvalid_o, 0); chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_eoa"}, eoa_o, 0);    chk({tag, "_ovr"}, ovr_o, 0);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check_reset(tag);
    rst = 1'b0;
  endtask

  initial begin : main
    int n;
    for (int c = 0; c < 8; c++) adc_val[c] = '0;
    repeat (2) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    adc_val[0] = 12'h123; adc_val[1] = 12'hABC;
    run_frame(2'b11, "f11");
    run_frame(2'b10, "f10");

    for (int it = 0; it < 4; it++) begin
      for (int c = 0; c < NCH; c++) adc_val[c] = 12'($urandom);
      run_frame(NCH'($urandom_range(1, 3)), $sformatf("rnd%0d", it));
    end

    // Overrun mid-frame, then again in the DONE cycle.
    for (int c = 0; c < NCH; c++) adc_val[c] = 12'($urandom);
    clear_logs(); build_exp(2'b11); mask = 2'b11;
    pulse_trig();
    repeat (300) @(negedge clk);
    pulse_trig();
    wait_eoa("ovr");
    chk("ovr_mid_cnt", ovr_cnt, 1);
    pulse_trig();
    chk("ovr_done", ovr_o, 1);
    repeat (2000) @(negedge clk);
    compare_frame("ovr");
    chk("ovr_frames", busy_t.size(), 1);
    chk("ovr_total", ovr_cnt, 2);

    clear_logs(); mask = '0;
    pulse_trig();
    repeat (300) @(negedge clk);
    chk("m0_busy", busy_seen, 0); chk("m0_ovr", ovr_cnt, 0);
    chk("m0_tx_low", tx_seen_low, 0); chk("m0_cs_low", cs_seen_low, 0);

    // Reset mid-SPI, then mid-UART byte; each followed by a clean frame.
    mask = 2'b11;
    pulse_trig();
    repeat (60) @(negedge clk);
    chk("rspi_cs_active", cs_o, 0);
    reset_pulse("rspi");
    repeat (120) @(negedge clk);
    for (int c = 0; c < NCH; c++) adc_val[c] = 12'($urandom);
    run_frame(2'b11, "after_rspi");

    pulse_trig();
    n = 0;
    while (tx_o !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    chk("ruart_tx_started", (n < 3000), 1);
    repeat (20) @(negedge clk);
    reset_pulse("ruart");
    repeat (120) @(negedge clk);
    for (int c = 0; c < NCH; c++) adc_val[c] = 12'($urandom);
    run_frame(2'b01, "after_ruart");

    clear_logs(); mask = 2'b11; en = 1'b1;
    n = 0;
    while (busy_t.size() < 4 && n < 8000) begin @(negedge clk); n++; end
    en = 1'b0;
    chk("per_starts", (busy_t.size() >= 4), 1);
    for (int i = 1; i < busy_t.size(); i++)
      chk($sformatf("per_gap%0d", i), busy_t[i] - busy_t[i-1], PERIOD);
    chk("per_ovr", ovr_cnt, 0);
    n = 0;
    while (busy_o !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    chk("per_idle", (n < 3000), 1);
    repeat (5) @(negedge clk);
    clear_logs();
    repeat (4000) @(negedge clk);
    chk("noen_starts", busy_t.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
